// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-control bundle: run control, redirect, imem port and decode-side handshake.
// The master modport is the fetch controller; the slave modport is its environment.
interface imem_fetch_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start;
    logic              stop;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [DATA_W-1:0] imem_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              busy;

    modport master (
        input  start, stop, redirect_valid, redirect_pc, imem_data, out_ready,
        output imem_addr, imem_we, out_valid, out_instr, out_pc, busy
    );

    modport slave (
        output start, stop, redirect_valid, redirect_pc, imem_data, out_ready,
        input  imem_addr, imem_we, out_valid, out_instr, out_pc, busy
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues reads to a 1-cycle-latency imem and
// pairs each returned word with its PC in a 2-entry skid buffer feeding decode.
module imem_fetch_ctrl #(
    parameter int              ADDR_W     = 8,
    parameter int              DATA_W     = 32,
    parameter int              IMEM_DEPTH = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    imem_fetch_ctrl_if.master  bus
);
    localparam int IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  pc, req_pc;
    logic              inflight;
    logic [1:0]        count, count_nx;
    logic [DATA_W-1:0] instr0, instr1, instr0_nx, instr1_nx;
    logic [IDX_W-1:0]  epc0, epc1, epc0_nx, epc1_nx;
    logic              deq, issue;
    logic [2:0]        occ;
    logic [IDX_W-1:0]  redir_idx;

    assign redir_idx = bus.redirect_pc[IDX_W-1:0];

    generate
        if (ADDR_W > IDX_W) begin : g_unused_hi
            logic unused_redir_hi;
            assign unused_redir_hi = ^bus.redirect_pc[ADDR_W-1:IDX_W];
        end
    endgenerate

    // Occupancy after this cycle's return and dequeue must leave room for the next return.
    always_comb begin
        deq   = (count != 2'd0) && bus.out_ready;
        occ   = 3'(count) + 3'(inflight) - 3'(deq);
        issue = (state == RUN) && !bus.redirect_valid && (occ < 3'd2);
    end

    always_comb begin
        state_nx = state;
        if (bus.redirect_valid) begin
            if (state == DRAIN) state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start && !bus.stop) state_nx = RUN;
                RUN:     if (bus.stop) state_nx = DRAIN;
                DRAIN: begin
                    if (bus.start && !bus.stop) state_nx = RUN;
                    else if (!inflight)         state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Entry 0 is the head; it keeps its contents when the buffer empties so out_* hold.
    always_comb begin
        count_nx  = count;
        instr0_nx = instr0;
        epc0_nx   = epc0;
        instr1_nx = instr1;
        epc1_nx   = epc1;
        if (bus.redirect_valid) begin
            count_nx = 2'd0;
        end else begin
            case ({deq, inflight})
                2'b10: begin
                    if (count == 2'd2) begin
                        instr0_nx = instr1;
                        epc0_nx   = epc1;
                    end
                    count_nx = count - 2'd1;
                end
                2'b01: begin
                    if (count == 2'd0) begin
                        instr0_nx = bus.imem_data;
                        epc0_nx   = req_pc;
                    end else begin
                        instr1_nx = bus.imem_data;
                        epc1_nx   = req_pc;
                    end
                    count_nx = count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        instr0_nx = instr1;
                        epc0_nx   = epc1;
                        instr1_nx = bus.imem_data;
                        epc1_nx   = req_pc;
                    end else begin
                        instr0_nx = bus.imem_data;
                        epc0_nx   = req_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC[IDX_W-1:0];
            inflight <= 1'b0;
            count    <= 2'd0;
            instr0   <= '0;
            epc0     <= '0;
        end else begin
            state    <= state_nx;
            inflight <= issue;
            count    <= count_nx;
            instr0   <= instr0_nx;
            epc0     <= epc0_nx;
            if (bus.redirect_valid) pc <= redir_idx;
            else if (issue)         pc <= pc + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        instr1 <= instr1_nx;
        epc1   <= epc1_nx;
        if (issue) req_pc <= pc;
    end

    assign bus.imem_addr = ADDR_W'(pc);
    assign bus.imem_we   = 1'b0;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = instr0;
    assign bus.out_pc    = ADDR_W'(epc0);
    assign bus.busy      = (state != IDLE) || inflight;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed fetch scenarios then random control traffic,
// checked every cycle against a queue-based model of the fetch rules.
module tb_imem_fetch_ctrl;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    typedef struct {
        int          pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DATA_W-1:0] mem [DEPTH];

    imem_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_fetch_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMEM_DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr[5:0]];

    int          n_chk  = 0;
    int          n_pass = 0;
    int          m_state, m_pc, m_req, m_infl, sh_pc;
    logic [31:0] sh_instr;
    ent_t        q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_pc     = int'(RESET_PC) % DEPTH;
        m_req    = 0;
        m_infl   = 0;
        sh_pc    = 0;
        sh_instr = '0;
        q.delete();
    endtask

    task automatic model_step(input bit st, input bit sp, input bit rv,
                              input logic [7:0] rpc, input bit ordy);
        int sz;
        bit deq, iss, was_infl;
        sz       = q.size();
        deq      = (sz > 0) && ordy;
        was_infl = (m_infl != 0);
        iss      = !rv && (m_state == M_RUN) && ((sz + m_infl - int'(deq)) < 2);
        if (rv) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (was_infl) q.push_back('{m_req, mem[m_req]});
        end
        if (q.size() > 0) begin
            sh_pc    = q[0].pc;
            sh_instr = q[0].instr;
        end
        m_infl = iss ? 1 : 0;
        if (iss) begin
            m_req = m_pc;
            m_pc  = (m_pc + 1) % DEPTH;
        end
        if (rv) begin
            m_pc = int'(rpc) % DEPTH;
            if (m_state == M_DRAIN) m_state = M_IDLE;
        end else if (m_state == M_IDLE) begin
            if (st && !sp) m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (sp) m_state = M_DRAIN;
        end else begin
            if (st && !sp)      m_state = M_RUN;
            else if (!was_infl) m_state = M_IDLE;
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() > 0));
        check({pfx, ".out_pc"},    64'(bus.out_pc),    64'(sh_pc));
        check({pfx, ".out_instr"}, 64'(bus.out_instr), 64'(sh_instr));
        check({pfx, ".imem_addr"}, 64'(bus.imem_addr), 64'(m_pc));
        check({pfx, ".busy"},      64'(bus.busy),      64'((m_state != M_IDLE) || (m_infl != 0)));
        check({pfx, ".imem_we"},   64'(bus.imem_we),   64'(0));
    endtask

    task automatic cyc(input string pfx, input bit st, input bit sp, input bit rv,
                       input logic [7:0] rpc, input bit ordy);
        bus.start          = st;
        bus.stop           = sp;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = ordy;
        @(posedge clk);
        model_step(st, sp, rv, rpc, ordy);
        @(negedge clk);
        check_outputs(pfx);
    endtask

    task automatic async_reset(input string pfx);
        bus.start          = 1'b0;
        bus.stop           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(pfx);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain_to_idle(input string pfx, input bit ordy);
        for (int i = 0; i < 10 && m_state != M_IDLE; i++) cyc(pfx, 0, 0, 0, 8'h00, ordy);
        check({pfx, ".reached_idle"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + 32'(i);
        bus.imem_data      = '0;
        bus.start          = 1'b0;
        bus.stop           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Free-running fetch, then a decode stall.
        cyc("t1", 1, 0, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) cyc("t1", 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) cyc("t2", 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) cyc("t2", 0, 0, 0, 8'h00, 1);

        // Redirect with a read in flight, then across the wrap point.
        cyc("t3", 0, 0, 1, 8'h20, 0);
        for (int i = 0; i < 5; i++) cyc("t3", 0, 0, 0, 8'h00, 1);
        cyc("t4", 0, 0, 1, 8'(DEPTH - 2), 1);
        for (int i = 0; i < 7; i++) cyc("t4", 0, 0, 0, 8'h00, 1);

        // Stop with decode stalled, drain to idle, resume.
        cyc("t5", 0, 1, 0, 8'h00, 1);
        drain_to_idle("t5", 1);
        cyc("t5", 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cyc("t5", 0, 0, 0, 8'h00, 0);
        cyc("t5", 0, 1, 0, 8'h00, 0);
        drain_to_idle("t5", 0);
        check("t5.buffered", 64'(q.size()), 64'(2));
        cyc("t5", 1, 0, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++) cyc("t5", 0, 0, 0, 8'h00, 1);

        // Reset while running with output valid; nothing until a new start.
        async_reset("t6");
        for (int i = 0; i < 3; i++) cyc("t6", 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

        for (int n = 0; n < 3000; n++) begin
            bit st, sp, rv, ordy;
            logic [7:0] rpc;
            st   = ($urandom_range(99) < 6);
            sp   = ($urandom_range(99) < 4);
            rv   = ($urandom_range(99) < 3);
            ordy = ($urandom_range(99) < 70);
            rpc  = 8'($urandom);
            if (rv) begin
                st = 1'b0;
                sp = 1'b0;
            end
            if ($urandom_range(999) < 3) async_reset("rnd_rst");
            else cyc("rnd", st, sp, rv, rpc, ordy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
